// File: rtl/signed_nibble_accumulator_pkg.sv
// Shared constants for the signed nibble accumulator: width, signed limits, op codes.
// Latency: none (declarations only).
// Backpressure: none.
package signed_nibble_accumulator_pkg;

   localparam int ACC_W = 4;

   localparam logic signed [ACC_W-1:0] SMAX = 4'sd7;
   localparam logic signed [ACC_W-1:0] SMIN = -4'sd8;

   typedef logic [1:0] op_t;

   localparam op_t OP_NONE = 2'd0;
   localparam op_t OP_ADD  = 2'd1;
   localparam op_t OP_SUB  = 2'd2;
   localparam op_t OP_CLR  = 2'd3;

   // Clear wins over everything; add and sub together cancel each other out.
   function automatic op_t op_decode(input logic add, input logic sub, input logic clr);
      op_t op;
      op = OP_NONE;
      if (clr)
         op = OP_CLR;
      else if (add && !sub)
         op = OP_ADD;
      else if (sub && !add)
         op = OP_SUB;
      return op;
   endfunction

endpackage

// File: rtl/signed_nibble_accumulator_if.sv
// Board-side bundle: switches, raw buttons and mode in; accumulator result out.
// Latency: none (wires only).
// Backpressure: none; the result is a level plus a one-cycle update strobe.
interface signed_nibble_accumulator_if import signed_nibble_accumulator_pkg::*; ();

   logic [ACC_W-1:0] sw;
   logic             key_add_n;
   logic             key_sub_n;
   logic             key_clr_n;
   logic             sat_mode;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic             op_strobe;

   modport master (
      output sw, key_add_n, key_sub_n, key_clr_n, sat_mode,
      input  acc, ovf, op_strobe
   );

   modport slave (
      input  sw, key_add_n, key_sub_n, key_clr_n, sat_mode,
      output acc, ovf, op_strobe
   );

endinterface

// File: rtl/signed_nibble_accumulator_key_debounce.sv
// Synchronize, debounce and edge-detect one active-low pushbutton into a press pulse.
// Latency: press_pulse rises DEBOUNCE_CYCLES+2 edges after the raw key is first sampled low.
// Backpressure: none; one pulse per debounced press, releases are silent.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press_pulse
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [1:0]    warm;
   logic          stable;
   logic          stable_d;
   logic          armed;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer; warm marks when sync2 carries real key data rather than reset fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         warm  <= 2'b00;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         warm  <= {warm[0], 1'b1};
      end
   end

   // Accept a new level only after it has differed from the stable level for the full window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         stable <= 1'b1;
      end else if (sync2 == stable) begin
         cnt <= '0;
      end else if (cnt == TC) begin
         cnt    <= '0;
         stable <= sync2;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Arm only once the key has been genuinely seen released, so a key held through reset stays silent.
   always_ff @(posedge clk) begin
      if (!rst_n)
         armed <= 1'b0;
      else if (warm[1] && sync2 && stable)
         armed <= 1'b1;
   end

   // Registered falling-edge detect on the debounced level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stable_d    <= 1'b1;
         press_pulse <= 1'b0;
      end else begin
         stable_d    <= stable;
         press_pulse <= armed && stable_d && !stable;
      end
   end

endmodule

// File: rtl/signed_nibble_accumulator.sv
// Signed 4-bit accumulator driven by debounced add/sub/clear buttons, with overflow flag and wrap/saturate.
// Latency: raw key low sampled at edge k updates acc/ovf/op_strobe at edge k+DEBOUNCE_CYCLES+4.
// Backpressure: none; every accepted press is applied, simultaneous add+sub is dropped.
module signed_nibble_accumulator
   import signed_nibble_accumulator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                        clk,
   input  logic                        rst_n,
   signed_nibble_accumulator_if.slave  bus
);

   logic add_p;
   logic sub_p;
   logic clr_p;
   op_t  op_q;

   logic [ACC_W-1:0] acc_q;
   logic             ovf_q;
   logic             strobe_q;

   logic signed [ACC_W:0] a_ext;
   logic signed [ACC_W:0] b_ext;
   logic signed [ACC_W:0] sum;
   logic                  of;
   logic [ACC_W-1:0]      res;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_add (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (bus.key_add_n),
      .press_pulse (add_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sub (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (bus.key_sub_n),
      .press_pulse (sub_p)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (bus.key_clr_n),
      .press_pulse (clr_p)
   );

   // Register the decoded op so it is applied on the cycle after the press pulses.
   always_ff @(posedge clk) begin
      if (!rst_n)
         op_q <= OP_NONE;
      else
         op_q <= op_decode(add_p, sub_p, clr_p);
   end

   // One-bit-wider signed add/sub; overflow when the top two result bits disagree.
   always_comb begin
      a_ext = {acc_q[ACC_W-1], acc_q};
      b_ext = {bus.sw[ACC_W-1], bus.sw};
      sum   = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
      of    = sum[ACC_W] ^ sum[ACC_W-1];
      res   = sum[ACC_W-1:0];
      if (bus.sat_mode && of)
         res = sum[ACC_W] ? SMIN : SMAX;
   end

   // Apply the op; sw and sat_mode only matter in this cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         ovf_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         case (op_q)
            OP_CLR: begin
               acc_q    <= '0;
               ovf_q    <= 1'b0;
               strobe_q <= 1'b1;
            end
            OP_ADD, OP_SUB: begin
               acc_q    <= res;
               ovf_q    <= of;
               strobe_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.acc       = acc_q;
   assign bus.ovf       = ovf_q;
   assign bus.op_strobe = strobe_q;

endmodule

// File: tb/tb_signed_nibble_accumulator.sv
// Directed bench for signed_nibble_accumulator with a strobe-driven scoreboard.
// Latency: expects each update exactly 8 edges after the key is first sampled (DEBOUNCE_CYCLES=4).
// Backpressure: none.
module tb_signed_nibble_accumulator;
   import signed_nibble_accumulator_pkg::*;

   typedef struct {
      logic [ACC_W-1:0] acc;
      logic             ovf;
      int               at;
      string            name;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   signed_nibble_accumulator_if bus ();

   signed_nibble_accumulator #(.DEBOUNCE_CYCLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Monitor: every strobe must match the oldest expected update, including its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.op_strobe === 1'b1) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_strobe: got acc=%h ovf=%b at cycle %0d, required no strobe",
                     bus.acc, bus.ovf, cyc);
         end else begin
            e = q.pop_front();
            if (bus.acc !== e.acc || bus.ovf !== e.ovf || cyc != e.at) begin
               bad++;
               $display("FAIL %s: got acc=%h ovf=%b cycle=%0d, required acc=%h ovf=%b cycle=%0d",
                        e.name, bus.acc, bus.ovf, cyc, e.acc, e.ovf, e.at);
            end
         end
      end
   end

   task automatic check(input string n, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h", n, got, req);
      end
   endtask

   task automatic press(input logic a, input logic s, input logic c,
                        input logic [ACC_W-1:0] sw_v, input logic sat,
                        input bit expect_upd, input logic [ACC_W-1:0] ea,
                        input logic eo, input string n);
      exp_t e;
      @(posedge clk); #1;
      bus.sw        = sw_v;
      bus.sat_mode  = sat;
      bus.key_add_n = ~a;
      bus.key_sub_n = ~s;
      bus.key_clr_n = ~c;
      if (expect_upd) begin
         e.acc  = ea;
         e.ovf  = eo;
         e.at   = cyc + 9;
         e.name = n;
         q.push_back(e);
      end
      repeat (12) @(posedge clk);
      #1;
      bus.key_add_n = 1'b1;
      bus.key_sub_n = 1'b1;
      bus.key_clr_n = 1'b1;
      repeat (12) @(posedge clk);
   endtask

   initial begin
      bus.sw        = '0;
      bus.sat_mode  = 1'b0;
      bus.key_add_n = 1'b0;
      bus.key_sub_n = 1'b0;
      bus.key_clr_n = 1'b0;

      // Reset with all keys held down.
      repeat (2) @(posedge clk);
      #1;
      check("rst_acc", bus.acc, 4'h0);
      check("rst_ovf", {3'b000, bus.ovf}, 4'h0);
      check("rst_strobe", {3'b000, bus.op_strobe}, 4'h0);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      bus.key_add_n = 1'b1;
      bus.key_sub_n = 1'b1;
      bus.key_clr_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      check("held_thru_reset", bus.acc, 4'h0);

      // Basic adds.
      press(1, 0, 0, 4'h3, 0, 1, 4'h3, 0, "add_3");
      press(1, 0, 0, 4'hE, 0, 1, 4'h1, 0, "add_m2");

      // Bouncing key never settles long enough.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1; bus.key_add_n = 1'b0;
         @(posedge clk);
         @(posedge clk); #1; bus.key_add_n = 1'b1;
         @(posedge clk);
      end
      repeat (15) @(posedge clk);
      #1;
      check("bounce_hold", bus.acc, 4'h1);

      // Positive overflow, wrap then saturate, ovf not sticky.
      press(1, 0, 0, 4'h6, 0, 1, 4'h7, 0, "add_to_7");
      press(1, 0, 0, 4'h1, 0, 1, 4'h8, 1, "wrap_pos");
      press(0, 0, 1, 4'h1, 0, 1, 4'h0, 0, "clr_1");
      press(1, 0, 0, 4'h7, 0, 1, 4'h7, 0, "add_7");
      press(1, 0, 0, 4'h1, 1, 1, 4'h7, 1, "sat_pos");
      press(1, 0, 0, 4'h0, 1, 1, 4'h7, 0, "ovf_clears");

      // Changing sw/sat_mode alone does nothing.
      @(posedge clk); #1;
      bus.sw       = 4'h5;
      bus.sat_mode = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("mode_change_hold", bus.acc, 4'h7);

      // Subtracting -8 from zero.
      press(0, 0, 1, 4'h0, 0, 1, 4'h0, 0, "clr_2");
      press(0, 1, 0, 4'h8, 0, 1, 4'h8, 1, "sub_m8_wrap");
      press(0, 0, 1, 4'h0, 0, 1, 4'h0, 0, "clr_3");
      press(0, 1, 0, 4'h8, 1, 1, 4'h7, 1, "sub_m8_sat");

      // Add and sub together cancel.
      press(1, 1, 0, 4'h1, 0, 0, 4'h0, 0, "addsub_noop");
      check("addsub_acc", bus.acc, 4'h7);
      check("addsub_ovf", {3'b000, bus.ovf}, 4'h1);

      // Plain subtract and negative saturation.
      press(0, 1, 0, 4'h2, 0, 1, 4'h5, 0, "sub_2");
      press(0, 0, 1, 4'h0, 0, 1, 4'h0, 0, "clr_4");
      press(0, 1, 0, 4'h7, 0, 1, 4'h9, 0, "sub_7");
      press(0, 1, 0, 4'h3, 1, 1, 4'h8, 1, "sat_neg");

      // Clear wins over a simultaneous add.
      press(1, 0, 1, 4'h5, 0, 1, 4'h0, 0, "clr_add");

      repeat (5) @(posedge clk);
      #1;
      check("pending_updates", 4'(q.size()), 4'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
